// File: rtl/valu_pkg.sv
// Shared types and helpers for the vector ALU sequencer: ALU opcodes, FSM states,
// lane count and opcode normalisation.
package valu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  function automatic int lanes(input int v, input int s);
    return v / s;
  endfunction

  // Opcodes 4..7 are not defined for the scalar ALU and are issued as add.
  function automatic alu_op_e norm_op(input logic [2:0] op);
    return op[2] ? OP_ADD : alu_op_e'(op);
  endfunction

endpackage

// File: rtl/vector_alu_sequencer_if.sv
// Vector request/result bus between the issue stage (master) and the sequencer (slave).
interface vector_alu_sequencer_if #(
  parameter int V = 192,
  parameter int S = 32
) ();
  localparam int LANES = valu_pkg::lanes(V, S);

  // Both channels are valid/ready: a transfer happens on a rising clk edge where
  // valid and ready are both high; valid and its payload stay stable until then.
  logic             in_valid;
  logic             in_ready;
  logic [V-1:0]     in_va;
  logic [V-1:0]     in_vb;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [V-1:0]     out_vc;
  logic [LANES-1:0] out_zmask;
  logic             out_allzero;

  modport master (
    output in_valid, in_va, in_vb, in_op, out_ready,
    input  in_ready, out_valid, out_vc, out_zmask, out_allzero
  );

  modport slave (
    input  in_valid, in_va, in_vb, in_op, out_ready,
    output in_ready, out_valid, out_vc, out_zmask, out_allzero
  );

endinterface

// File: rtl/vector_alu_sequencer.sv
// Issues a V-bit vector op lane by lane to an external scalar ALU and reassembles
// the result. Optional feature: VALU_DIVZERO_FLAG_EN adds per-lane divide-by-zero flags.
module vector_alu_sequencer
  import valu_pkg::*;
#(
  parameter int V = 192,
  parameter int S = 32,
  localparam int LANES = lanes(V, S)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vector_alu_sequencer_if.slave  bus,
  output logic [S-1:0]           alu_a,
  output logic [S-1:0]           alu_b,
  output logic [2:0]             alu_sel,
  input  logic [S-1:0]           alu_c,
  input  logic                   alu_z,
  output seq_state_e             dbg_state
`ifdef VALU_DIVZERO_FLAG_EN
  ,
  output logic [LANES-1:0]       out_divz
`endif
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  generate
    if (V % S != 0) begin : g_bad_width
      $error("vector_alu_sequencer: V must be a multiple of S");
    end
  endgenerate

  seq_state_e       state;
  logic [LW-1:0]    lane;
  logic [V-1:0]     va_q;
  logic [V-1:0]     vb_q;
  alu_op_e          op_q;
  logic [V-1:0]     vc_q;
  logic [LANES-1:0] zmask_q;

  logic             accept;
  logic [S-1:0]     lane_a;
  logic [S-1:0]     lane_b;
  logic [S-1:0]     lane_c;
  logic             lane_z;

  assign bus.in_ready = rst_n && ((state == IDLE) || ((state == DONE) && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    lane_a = va_q[lane*S +: S];
    lane_b = vb_q[lane*S +: S];
  end

`ifdef VALU_DIVZERO_FLAG_EN
  logic             lane_dz;
  logic [LANES-1:0] divz_q;

  // A zero divisor overrides whatever the ALU returns with a saturated, non-zero result.
  always_comb begin
    lane_dz = (op_q == OP_DIV) && (lane_b == '0);
    lane_c  = lane_dz ? {S{1'b1}} : alu_c;
    lane_z  = lane_dz ? 1'b0 : alu_z;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      divz_q <= '0;
    end else if (state == RUN) begin
      divz_q[lane] <= lane_dz;
    end
  end

  assign out_divz = divz_q;
`else
  always_comb begin
    lane_c = alu_c;
    lane_z = alu_z;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lane    <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      op_q    <= OP_ADD;
      vc_q    <= '0;
      zmask_q <= '0;
    end else begin
      // accept can only be high in IDLE or DONE, so it never collides with the RUN lane step.
      if (accept) begin
        va_q <= bus.in_va;
        vb_q <= bus.in_vb;
        op_q <= norm_op(bus.in_op);
        lane <= '0;
      end
      unique case (state)
        IDLE: begin
          if (accept) state <= RUN;
        end
        RUN: begin
          vc_q[lane*S +: S] <= lane_c;
          zmask_q[lane]     <= lane_z;
          if (lane == LW'(LANES - 1)) state <= DONE;
          else                        lane  <= lane + 1'b1;
        end
        DONE: begin
          if (bus.out_ready) state <= bus.in_valid ? RUN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_a   = (rst_n && state == RUN) ? lane_a : '0;
  assign alu_b   = (rst_n && state == RUN) ? lane_b : '0;
  assign alu_sel = (rst_n && state == RUN) ? op_q   : 3'd0;

  assign bus.out_valid   = (state == DONE);
  assign bus.out_vc      = vc_q;
  assign bus.out_zmask   = zmask_q;
  assign bus.out_allzero = &zmask_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Bench for vector_alu_sequencer with a behavioural scalar ALU beside it; honours VALU_DIVZERO_FLAG_EN.
module tb_vector_alu_sequencer;
  import valu_pkg::*;

  localparam int V     = 192;
  localparam int S     = 32;
  localparam int LANES = V / S;
  localparam int EW    = V + 2 * LANES + 1;

  logic             clk;
  logic             rst_n;
  logic [S-1:0]     alu_a;
  logic [S-1:0]     alu_b;
  logic [2:0]       alu_sel;
  logic [S-1:0]     alu_c;
  logic             alu_z;
  seq_state_e       dbg_state;
  logic [LANES-1:0] divz_obs;

  vector_alu_sequencer_if #(.V(V), .S(S)) vif ();

`ifdef VALU_DIVZERO_FLAG_EN
  vector_alu_sequencer #(.V(V), .S(S)) dut (
    .clk(clk), .rst_n(rst_n), .bus(vif),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c), .alu_z(alu_z),
    .dbg_state(dbg_state), .out_divz(divz_obs)
  );
`else
  vector_alu_sequencer #(.V(V), .S(S)) dut (
    .clk(clk), .rst_n(rst_n), .bus(vif),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c), .alu_z(alu_z),
    .dbg_state(dbg_state)
  );
  assign divz_obs = '0;
`endif

  // Scalar ALU; this one defines x / 0 as 0.
  always_comb begin
    alu_c = '0;
    case (alu_sel)
      3'd1:    alu_c = alu_a - alu_b;
      3'd2:    alu_c = alu_a * alu_b;
      3'd3:    alu_c = (alu_b == '0) ? '0 : alu_a / alu_b;
      default: alu_c = alu_a + alu_b;
    endcase
    alu_z = (alu_c == '0);
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  bit            lat_armed = 1'b1;
  bit            rand_rdy  = 1'b0;
  int            checks    = 0;
  int            failures  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (bound expired)", name);
  endtask

  // Reference: per-lane plain arithmetic modulo 2^S.
  function automatic logic [EW-1:0] model(input logic [V-1:0] va, input logic [V-1:0] vb,
                                          input logic [2:0] op);
    logic [V-1:0]     vc;
    logic [LANES-1:0] zm;
    logic [LANES-1:0] dz;
    longint unsigned  a, b, r, mask;
    int               eff;
    mask = (64'd1 << S) - 64'd1;
    eff  = (op > 3'd3) ? 0 : int'(op);
    vc = '0; zm = '0; dz = '0;
    for (int k = 0; k < LANES; k++) begin
      a = longint'(va[k*S +: S]);
      b = longint'(vb[k*S +: S]);
      case (eff)
        1:       r = a - b;
        2:       r = a * b;
        3:       r = (b == 0) ? 0 : a / b;
        default: r = a + b;
      endcase
      r = r & mask;
      zm[k] = (r == 0);
`ifdef VALU_DIVZERO_FLAG_EN
      if (eff == 3 && b == 0) begin
        r     = mask;
        zm[k] = 1'b0;
        dz[k] = 1'b1;
      end
`endif
      vc[k*S +: S] = r[S-1:0];
    end
    return {dz, &zm, zm, vc};
  endfunction

  function automatic logic [V-1:0] mk(input logic [S-1:0] l0, l1, l2, l3, l4, l5);
    return {l5, l4, l3, l2, l1, l0};
  endfunction

  // Issue side: expectation recorded at the accept handshake.
  always @(negedge clk) begin
    if (rst_n && vif.in_valid && vif.in_ready) begin
      exp_q.push_back(model(vif.in_va, vif.in_vb, vif.in_op));
      acc_q.push_back(cyc);
    end
  end

  // Monitor: latency of each result and content at the output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vif.out_valid && lat_armed) begin
        if (acc_q.size() == 0) fail_now("latency_no_accept");
        else check("latency", cyc - acc_q.pop_front(), LANES + 1);
        lat_armed = 1'b0;
      end
      if (vif.out_valid && vif.out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else check("result", {divz_obs, vif.out_allzero, vif.out_zmask, vif.out_vc}, exp_q.pop_front());
        lat_armed = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) vif.out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [V-1:0] va, input logic [V-1:0] vb, input logic [2:0] op,
                      output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    vif.in_valid = 1'b1;
    vif.in_va    = va;
    vif.in_vb    = vb;
    vif.in_op    = op;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (vif.in_ready) begin
        acc = cyc;
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("send_timeout");
    @(posedge clk); #1;
    vif.in_valid = 1'b0;
    vif.in_va    = $urandom();
    vif.in_op    = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (vif.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now(name);
  endtask

  task automatic release_out();
    @(posedge clk); #1;
    vif.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !vif.out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now(name);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int               acc, c0, nvalid;
    logic [V-1:0]     snap_vc, va, vb;
    logic [LANES-1:0] snap_zm;

    rst_n         = 1'b0;
    vif.in_valid  = 1'b0;
    vif.in_va     = '0;
    vif.in_vb     = '0;
    vif.in_op     = '0;
    vif.out_ready = 1'b1;

    @(posedge clk); #1;
    @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_in_ready", vif.in_ready, 1'b0);
    check("rst_out_valid", vif.out_valid, 1'b0);
    check("rst_out_vc", vif.out_vc, '0);
    check("rst_alu_a", {alu_sel, alu_b, alu_a}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", vif.in_ready, 1'b1);
    @(posedge clk); #1;

    // 1. add
    vif.out_ready = 1'b0;
    send(mk(1, 2, 3, 4, 5, 6), mk(10, 10, 10, 10, 10, 10), 3'd0, acc);
    wait_valid("add_wait");
    check("add_vc", vif.out_vc, mk(11, 12, 13, 14, 15, 16));
    check("add_zmask", vif.out_zmask, '0);
    check("add_allzero", vif.out_allzero, 1'b0);
    release_out();

    // 2. sub to zero
    vif.out_ready = 1'b0;
    send(mk(5, 0, 7, 0, 9, 0), mk(5, 0, 7, 0, 9, 0), 3'd1, acc);
    wait_valid("subz_wait");
    check("subz_vc", vif.out_vc, '0);
    check("subz_zmask", vif.out_zmask, 6'b111111);
    check("subz_allzero", vif.out_allzero, 1'b1);
    release_out();

    // 3. mul wrap and sub wrap
    vif.out_ready = 1'b0;
    send(mk(32'h0001_0000, 3, 2, 9, 32'hFFFF_FFFF, 0), mk(32'h0001_0000, 7, 5, 0, 2, 8), 3'd2, acc);
    wait_valid("mul_wait");
    check("mul_lane0", vif.out_vc[31:0], 32'd0);
    check("mul_z0", vif.out_zmask[0], 1'b1);
    check("mul_lane1", vif.out_vc[63:32], 32'd21);
    check("mul_lane4", vif.out_vc[159:128], 32'hFFFF_FFFE);
    release_out();
    vif.out_ready = 1'b0;
    send(mk(0, 1, 2, 3, 4, 5), mk(1, 1, 1, 1, 1, 1), 3'd1, acc);
    wait_valid("subw_wait");
    check("subw_lane0", vif.out_vc[31:0], 32'hFFFF_FFFF);
    check("subw_zmask", vif.out_zmask, 6'b000010);
    release_out();

    // 4. backpressure then back-to-back accept
    vif.out_ready = 1'b0;
    send(mk(8, 7, 6, 5, 4, 3), mk(1, 2, 3, 4, 5, 6), 3'd2, acc);
    wait_valid("bp_wait");
    snap_vc = vif.out_vc;
    snap_zm = vif.out_zmask;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", vif.out_valid, 1'b1);
      check("bp_in_ready", vif.in_ready, 1'b0);
      check("bp_vc_stable", vif.out_vc, snap_vc);
      check("bp_zm_stable", vif.out_zmask, snap_zm);
    end
    @(posedge clk); #1;
    vif.out_ready = 1'b1;
    c0 = cyc;
    send(mk(100, 200, 300, 400, 500, 600), mk(1, 2, 3, 4, 5, 6), 3'd1, acc);
    check("b2b_same_cycle", acc, c0);
    wait_drain("b2b_drain");

    // 5. reset while lane 3 is in flight
    send(mk(1, 1, 1, 1, 1, 1), mk(2, 2, 2, 2, 2, 2), 3'd0, acc);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    lat_armed = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstrun_state", dbg_state, IDLE);
    check("rstrun_vc", vif.out_vc, '0);
    check("rstrun_zmask", vif.out_zmask, '0);
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vif.out_valid) nvalid++;
    end
    check("rstrun_no_valid", nvalid, 0);
    @(posedge clk); #1;
    send(mk(9, 8, 7, 6, 5, 4), mk(1, 1, 1, 1, 1, 1), 3'd0, acc);
    wait_drain("rstrun_fresh");

    // 6. div with a zero divisor in lane 1, then op 5 as add
    vif.out_ready = 1'b0;
    send(mk(100, 55, 81, 7, 0, 9), mk(7, 0, 9, 7, 3, 10), 3'd3, acc);
    wait_valid("div_wait");
    check("div_lane0", vif.out_vc[31:0], 32'd14);
`ifdef VALU_DIVZERO_FLAG_EN
    check("div_lane1", vif.out_vc[63:32], 32'hFFFF_FFFF);
    check("div_divz", divz_obs, 6'b000010);
    check("div_z1", vif.out_zmask[1], 1'b0);
`else
    check("div_lane1", vif.out_vc[63:32], 32'd0);
    check("div_z1", vif.out_zmask[1], 1'b1);
`endif
    release_out();
    vif.out_ready = 1'b0;
    send(mk(1, 2, 3, 4, 5, 6), mk(6, 5, 4, 3, 2, 1), 3'd5, acc);
    wait_valid("op5_wait");
    check("op5_vc", vif.out_vc, mk(7, 7, 7, 7, 7, 7));
    release_out();

    // Random vectors against the reference with random consumer stalls.
    rand_rdy = 1'b1;
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < LANES; k++) begin
        case ($urandom_range(0, 3))
          0:       va[k*S +: S] = '0;
          1:       va[k*S +: S] = S'($urandom_range(0, 9));
          default: va[k*S +: S] = $urandom();
        endcase
        case ($urandom_range(0, 3))
          0:       vb[k*S +: S] = '0;
          1:       vb[k*S +: S] = va[k*S +: S];
          2:       vb[k*S +: S] = S'($urandom_range(1, 9));
          default: vb[k*S +: S] = $urandom();
        endcase
      end
      send(va, vb, 3'($urandom_range(0, 7)), acc);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    vif.out_ready = 1'b1;
    wait_drain("random_drain");
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

endmodule
